rv_instr_encoder: RTL and testbench

- Sequential RV32I instruction encoder and instruction-memory loader: the write side of the main decoder's opcode/immediate interface.
- Accepts one decoded-form instruction per handshake (class, funct bits, register indices, signed immediate), range-checks it, packs it into a 32-bit word, and writes it into instruction memory at consecutive word addresses.
- Used by the testbench and boot path to preload programs.

---
 rtl/rv_pkg.sv | 41 ++++
 rtl/rv_imm_pack.sv | 40 ++++
 rtl/rv_instr_encoder.sv | 230 +++++++++++++++++++++++
 tb/tb_rv_instr_encoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants used by both the instruction decoder and the
// program-loading encoder, so the two blocks agree on a single definition.
package rv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    typedef enum logic [2:0] {
        CLS_LOAD   = 3'd0,
        CLS_STORE  = 3'd1,
        CLS_BRANCH = 3'd2,
        CLS_OPIMM  = 3'd3,
        CLS_OP     = 3'd4,
        CLS_JAL    = 3'd5
    } cls_e;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2,
        IMM_J = 2'd3
    } imm_src_e;

    // One bit per funct3 value: bit n set means funct3 == n is a legal encoding.
    localparam logic [7:0] F3_LOAD_OK   = 8'b0011_0111;
    localparam logic [7:0] F3_STORE_OK  = 8'b0000_0111;
    localparam logic [7:0] F3_BRANCH_OK = 8'b1111_0011;
    localparam logic [7:0] F3_OP_ALT_OK = 8'b0010_0001;

    localparam logic [2:0] F3_SLL = 3'd1;
    localparam logic [2:0] F3_SRX = 3'd5;

    function automatic logic f3_ok(input logic [7:0] mask, input logic [2:0] f3);
        return mask[f3];
    endfunction

endpackage

// File: rtl/rv_imm_pack.sv
// Places a two's-complement immediate into its RV32I I/S/B/J bit positions and
// reports whether the value is representable; inverse of the immediate extender.
module rv_imm_pack
    import rv_pkg::*;
(
    input  imm_src_e    fmt,
    input  logic [20:0] imm,
    output logic [31:0] bits,
    output logic        range_ok
);

    // Bit scatter and representability per immediate format.
    always_comb begin
        bits     = 32'h0000_0000;
        range_ok = 1'b0;
        case (fmt)
            IMM_I: begin
                bits     = {imm[11:0], 20'h0_0000};
                range_ok = (&imm[20:11]) | (~|imm[20:11]);
            end
            IMM_S: begin
                bits     = {imm[11:5], 13'h0000, imm[4:0], 7'h00};
                range_ok = (&imm[20:11]) | (~|imm[20:11]);
            end
            IMM_B: begin
                bits     = {imm[12], imm[10:5], 13'h0000, imm[4:1], imm[11], 7'h00};
                range_ok = ((&imm[20:12]) | (~|imm[20:12])) & ~imm[0];
            end
            IMM_J: begin
                bits     = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h000};
                range_ok = ~imm[0];
            end
            default: begin
                bits     = 32'h0000_0000;
                range_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// Sequential RV32I encoder: accepts decoded-form beats, checks legality, packs
// them and writes consecutive instruction-memory words for one load session.
module rv_instr_encoder
    import rv_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    input  logic [2:0]        s_cls,
    input  logic [2:0]        s_funct3,
    input  logic              s_funct7b5,
    input  logic [4:0]        s_rd,
    input  logic [4:0]        s_rs1,
    input  logic [4:0]        s_rs2,
    input  logic [20:0]       s_imm,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic [ADDR_W:0]   n_written
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_e             state_r, state_nxt_s;
    logic [ADDR_W-1:0]  addr_r, addr_nxt_s;
    logic [ADDR_W:0]    n_written_r, n_nxt_s;
    logic               err_r, err_nxt_s, ovf_r, ovf_nxt_s;
    logic               s_ready_r, ready_nxt_s, busy_r, done_r;
    logic               im_we_r;
    logic [ADDR_W-1:0]  im_addr_r;
    logic [31:0]        im_wdata_r;

    logic               s1_valid_r, s1_last_r, s1_f7b5_r;
    logic [2:0]         s1_cls_r, s1_f3_r;
    logic [4:0]         s1_rd_r, s1_rs1_r, s1_rs2_r;
    logic [20:0]        s1_imm_r;

    imm_src_e           fmt_s;
    logic [31:0]        imm_bits_s, enc_s;
    logic               range_ok_s, legal_s;
    logic               accept_s, wr_s, drop_s, at_top_s, top_wr_s;

    assign accept_s = s_valid & s_ready_r;
    assign wr_s     = s1_valid_r & legal_s;
    assign drop_s   = s1_valid_r & ~legal_s;
    assign at_top_s = (addr_r == ADDR_MAX);
    assign top_wr_s = wr_s & at_top_s & ~s1_last_r;

    // Immediate format implied by the stage-1 instruction class.
    always_comb begin
        fmt_s = IMM_I;
        case (s1_cls_r)
            CLS_STORE:  fmt_s = IMM_S;
            CLS_BRANCH: fmt_s = IMM_B;
            CLS_JAL:    fmt_s = IMM_J;
            default:    fmt_s = IMM_I;
        endcase
    end

    rv_imm_pack u_imm_pack (
        .fmt      (fmt_s),
        .imm      (s1_imm_r),
        .bits     (imm_bits_s),
        .range_ok (range_ok_s)
    );

    // Stage 2: pack the instruction word and decide whether it is legal.
    always_comb begin
        enc_s   = 32'h0000_0000;
        legal_s = 1'b0;
        case (s1_cls_r)
            CLS_LOAD: begin
                enc_s   = imm_bits_s | {12'h000, s1_rs1_r, s1_f3_r, s1_rd_r, OPC_LOAD};
                legal_s = f3_ok(F3_LOAD_OK, s1_f3_r) & range_ok_s;
            end
            CLS_STORE: begin
                enc_s   = imm_bits_s | {7'h00, s1_rs2_r, s1_rs1_r, s1_f3_r, 5'h00, OPC_STORE};
                legal_s = f3_ok(F3_STORE_OK, s1_f3_r) & range_ok_s;
            end
            CLS_BRANCH: begin
                enc_s   = imm_bits_s | {7'h00, s1_rs2_r, s1_rs1_r, s1_f3_r, 5'h00, OPC_BRANCH};
                legal_s = f3_ok(F3_BRANCH_OK, s1_f3_r) & range_ok_s;
            end
            CLS_OPIMM: begin
                // Shift-immediates carry a 5-bit shamt and reuse bit 30 as the arithmetic flag.
                if ((s1_f3_r == F3_SLL) || (s1_f3_r == F3_SRX)) begin
                    enc_s   = {1'b0, s1_f7b5_r, 5'h00, s1_imm_r[4:0], s1_rs1_r, s1_f3_r,
                               s1_rd_r, OPC_OPIMM};
                    legal_s = (~|s1_imm_r[20:5]) & ~(s1_f7b5_r & (s1_f3_r == F3_SLL));
                end else begin
                    enc_s   = imm_bits_s | {12'h000, s1_rs1_r, s1_f3_r, s1_rd_r, OPC_OPIMM};
                    legal_s = range_ok_s;
                end
            end
            CLS_OP: begin
                enc_s   = {1'b0, s1_f7b5_r, 5'h00, s1_rs2_r, s1_rs1_r, s1_f3_r, s1_rd_r, OPC_OP};
                legal_s = ~s1_f7b5_r | f3_ok(F3_OP_ALT_OK, s1_f3_r);
            end
            CLS_JAL: begin
                enc_s   = imm_bits_s | {20'h0_0000, s1_rd_r, OPC_JAL};
                legal_s = range_ok_s;
            end
            default: begin
                enc_s   = 32'h0000_0000;
                legal_s = 1'b0;
            end
        endcase
    end

    // Session FSM, address/count bookkeeping and next-cycle ready.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        n_nxt_s     = n_written_r;
        err_nxt_s   = err_r | drop_s;
        ovf_nxt_s   = ovf_r | top_wr_s;
        if (wr_s) begin
            n_nxt_s    = n_written_r + CNT_ONE;
            addr_nxt_s = at_top_s ? addr_r : (addr_r + ADDR_ONE);
        end else begin
            n_nxt_s    = n_written_r;
            addr_nxt_s = addr_r;
        end
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    addr_nxt_s  = base_addr;
                    n_nxt_s     = {(ADDR_W+1){1'b0}};
                    err_nxt_s   = 1'b0;
                    ovf_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if ((accept_s && s_last) || top_wr_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: state_nxt_s = ST_DONE;
            default:  state_nxt_s = ST_IDLE;
        endcase
        // A beat accepted now sits in stage 1 next cycle; stall if it targets the top word.
        ready_nxt_s = (state_nxt_s == ST_RUN) && !(accept_s && (addr_nxt_s == ADDR_MAX));
    end

    // State, counters, stage-1 register and registered memory-write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            n_written_r <= {(ADDR_W+1){1'b0}};
            err_r       <= 1'b0;
            ovf_r       <= 1'b0;
            s_ready_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            im_we_r     <= 1'b0;
            im_addr_r   <= {ADDR_W{1'b0}};
            im_wdata_r  <= 32'h0000_0000;
            s1_valid_r  <= 1'b0;
            s1_last_r   <= 1'b0;
            s1_f7b5_r   <= 1'b0;
            s1_cls_r    <= 3'd0;
            s1_f3_r     <= 3'd0;
            s1_rd_r     <= 5'd0;
            s1_rs1_r    <= 5'd0;
            s1_rs2_r    <= 5'd0;
            s1_imm_r    <= 21'd0;
        end else begin
            state_r     <= state_nxt_s;
            addr_r      <= addr_nxt_s;
            n_written_r <= n_nxt_s;
            err_r       <= err_nxt_s;
            ovf_r       <= ovf_nxt_s;
            s_ready_r   <= ready_nxt_s;
            busy_r      <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
            done_r      <= (state_nxt_s == ST_DONE);
            im_we_r     <= wr_s;
            if (wr_s) begin
                im_addr_r  <= addr_r;
                im_wdata_r <= enc_s;
            end
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_last_r <= s_last;
                s1_f7b5_r <= s_funct7b5;
                s1_cls_r  <= s_cls;
                s1_f3_r   <= s_funct3;
                s1_rd_r   <= s_rd;
                s1_rs1_r  <= s_rs1;
                s1_rs2_r  <= s_rs2;
                s1_imm_r  <= s_imm;
            end
        end
    end

    assign s_ready   = s_ready_r;
    assign im_we     = im_we_r;
    assign im_addr   = im_addr_r;
    assign im_wdata  = im_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign ovf       = ovf_r;
    assign n_written = n_written_r;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Scoreboard bench for rv_instr_encoder: directed vectors plus random sessions
// checked against an arithmetic reference encoder.
module tb_rv_instr_encoder;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n, start, s_valid, s_last, s_funct7b5;
    logic [AW-1:0] base_addr;
    logic [2:0]    s_cls, s_funct3;
    logic [4:0]    s_rd, s_rs1, s_rs2;
    logic [20:0]   s_imm;
    logic          s_ready, im_we, busy, done, err, ovf;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [AW:0]   n_written;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_addr, m_n;
    bit   m_err, m_ovf, m_open;

    always #5 clk = ~clk;

    rv_instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_cls(s_cls),
        .s_funct3(s_funct3), .s_funct7b5(s_funct7b5), .s_rd(s_rd), .s_rs1(s_rs1),
        .s_rs2(s_rs2), .s_imm(s_imm), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .busy(busy), .done(done), .err(err), .ovf(ovf),
        .n_written(n_written)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference encoder: field positions from the ISA tables, signed range tests on int.
    function automatic bit model_enc(input int cls, input int f3, input int f7, input int rd,
                                     input int rs1, input int rs2, input int imm,
                                     output logic [31:0] w);
        logic [31:0] u;
        bit ok;
        u = imm;
        w = 32'h0;
        ok = 1'b0;
        case (cls)
            0: begin
                ok = (f3 inside {0, 1, 2, 4, 5}) && imm >= -2048 && imm <= 2047;
                w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
            end
            1: begin
                ok = f3 <= 2 && imm >= -2048 && imm <= 2047;
                w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                    | ((u & 32'h1F) << 7) | 32'h23;
            end
            2: begin
                ok = !(f3 inside {2, 3}) && imm >= -4096 && imm <= 4094 && (imm % 2) == 0;
                w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                    | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
                    | (((u >> 11) & 32'h1) << 7) | 32'h63;
            end
            3: begin
                if (f3 == 1 || f3 == 5) begin
                    ok = imm >= 0 && imm <= 31 && !(f7 == 1 && f3 == 1);
                    w = (f7 << 30) | ((u & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12)
                        | (rd << 7) | 32'h13;
                end else begin
                    ok = imm >= -2048 && imm <= 2047;
                    w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
                end
            end
            4: begin
                ok = (f7 == 0) || f3 == 0 || f3 == 5;
                w = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            end
            5: begin
                ok = (imm % 2) == 0;
                w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                    | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12)
                    | (rd << 7) | 32'h6F;
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    task automatic model_accept(input int cls, input int f3, input int f7, input int rd,
                                input int rs1, input int rs2, input int imm, input bit last,
                                input bit use_exp, input logic [31:0] exp_w);
        logic [31:0] w;
        exp_t e;
        if (!m_open) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_after_end: got accept expected none");
        end
        if (model_enc(cls, f3, f7, rd, rs1, rs2, imm, w)) begin
            e.addr = m_addr[AW-1:0];
            e.data = use_exp ? exp_w : w;
            exp_q.push_back(e);
            m_n++;
            if (m_addr == (1 << AW) - 1 && !last) begin
                m_ovf = 1'b1;
                m_open = 1'b0;
            end else begin
                m_addr++;
            end
        end else begin
            m_err = 1'b1;
        end
        if (last) m_open = 1'b0;
    endtask

    // Monitor: every memory write must match the head of the scoreboard queue.
    always @(negedge clk) begin
        exp_t e;
        if (im_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         im_addr, im_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(im_addr), 32'(e.addr));
                chk("write_data", im_wdata, e.data);
            end
        end
    end

    task automatic start_session(input int b);
        start = 1'b1;
        base_addr = b[AW-1:0];
        m_addr = b; m_n = 0; m_err = 1'b0; m_ovf = 1'b0; m_open = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("session_busy", 32'(busy), 32'd1);
        chk("session_cleared", {n_written, err, ovf}, 32'd0);
    endtask

    task automatic send(input int cls, input int f3, input int f7, input int rd, input int rs1,
                        input int rs2, input int imm, input bit last, input bit use_exp,
                        input logic [31:0] exp_w, input int bound, output bit acc);
        bit got = 1'b0;
        s_valid = 1'b1; s_last = last; s_cls = cls[2:0]; s_funct3 = f3[2:0];
        s_funct7b5 = f7[0]; s_rd = rd[4:0]; s_rs1 = rs1[4:0]; s_rs2 = rs2[4:0];
        s_imm = imm[20:0];
        for (int i = 0; i < bound && !got; i++) begin
            if (s_ready) begin
                got = 1'b1;
                model_accept(cls, f3, f7, rd, rs1, rs2, imm, last, use_exp, exp_w);
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        acc = got;
    endtask

    task automatic end_session();
        for (int i = 0; i < 30 && !done; i++) @(negedge clk);
        @(negedge clk);
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_err", 32'(err), 32'(m_err));
        chk("end_ovf", 32'(ovf), 32'(m_ovf));
        chk("end_n_written", 32'(n_written), 32'(m_n));
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {im_wdata}, 32'd0);
        chk(name, {s_ready, im_we, busy, done, err, ovf, im_addr, n_written}, 32'd0);
    endtask

    function automatic int rand_imm();
        int v;
        int edges[12] = '{-4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095, 31, 32, -1, 0};
        case ($urandom_range(0, 2))
            0: v = int'($urandom_range(0, 80)) - 40;
            1: begin
                v = int'($urandom & 32'h1F_FFFF);
                if (v >= 1048576) v = v - 2097152;
            end
            default: v = edges[$urandom_range(0, 11)];
        endcase
        return v;
    endfunction

    initial begin
        bit acc;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; s_valid = 1'b0; s_last = 1'b0;
        s_cls = 3'd0; s_funct3 = 3'd0; s_funct7b5 = 1'b0; s_rd = 5'd0; s_rs1 = 5'd0;
        s_rs2 = 5'd0; s_imm = 21'd0;
        m_open = 1'b0; m_addr = 0; m_n = 0; m_err = 1'b0; m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed program: addi, sub, sw, jal.
        start_session(16);
        send(3, 0, 0, 1, 0, 0, 5, 1'b0, 1'b1, 32'h0050_0093, 10, acc);
        chk("addi_accepted", 32'(acc), 32'd1);
        chk("addi_no_write_at_accept", 32'(im_we), 32'd0);
        @(negedge clk);
        chk("addi_write_next_cycle", 32'(im_we), 32'd1);
        send(4, 0, 1, 3, 1, 2, 0, 1'b0, 1'b1, 32'h4020_81B3, 10, acc);
        send(1, 2, 0, 0, 1, 2, 8, 1'b0, 1'b1, 32'h0020_A423, 10, acc);
        send(5, 0, 0, 1, 0, 0, -4, 1'b1, 1'b1, 32'hFFDF_F0EF, 10, acc);
        end_session();

        // Illegal branch between two good beats.
        start_session(64);
        send(0, 2, 0, 5, 6, 0, -12, 1'b0, 1'b0, 32'h0, 10, acc);
        send(2, 0, 0, 0, 1, 2, 3, 1'b0, 1'b0, 32'h0, 10, acc);
        send(0, 4, 0, 7, 8, 0, 2047, 1'b1, 1'b0, 32'h0, 10, acc);
        end_session();

        // Shift-immediate shamt boundary.
        start_session(80);
        send(3, 5, 1, 1, 2, 0, 31, 1'b0, 1'b1, 32'h41F1_5093, 10, acc);
        send(3, 5, 1, 1, 2, 0, 32, 1'b1, 1'b0, 32'h0, 10, acc);
        end_session();

        // Memory top reached before s_last.
        start_session((1 << AW) - 2);
        send(3, 0, 0, 1, 0, 0, 1, 1'b0, 1'b0, 32'h0, 10, acc);
        send(3, 0, 0, 2, 0, 0, 2, 1'b0, 1'b0, 32'h0, 10, acc);
        chk("ovf_ready_low", 32'(s_ready), 32'd0);
        send(3, 0, 0, 3, 0, 0, 3, 1'b0, 1'b0, 32'h0, 6, acc);
        chk("ovf_beat3_rejected", 32'(acc), 32'd0);
        end_session();

        // Reset the cycle after an accept: nothing may be written.
        start_session(32);
        send(3, 0, 0, 1, 0, 0, 9, 1'b0, 1'b0, 32'h0, 10, acc);
        rst_n = 1'b0;
        exp_q.delete();
        m_open = 1'b0;
        @(negedge clk);
        chk_all_zero("midsession_reset");
        rst_n = 1'b1;
        @(negedge clk);
        start_session(48);
        send(4, 7, 0, 9, 10, 11, 0, 1'b1, 1'b0, 32'h0, 10, acc);
        end_session();

        // Random sessions, the last one starting near the top of memory.
        for (int s = 0; s < 6; s++) begin
            int nb;
            start_session(s == 5 ? 246 : int'($urandom_range(0, 200)));
            nb = $urandom_range(6, 14);
            for (int b = 0; b < nb && m_open; b++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                send($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                     $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     rand_imm(), b == nb - 1, 1'b0, 32'h0, 10, acc);
                if (!acc) chk("rand_accept_timeout", 32'(acc), 32'd1);
            end
            end_session();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
